// File: rtl/lsp_expand_2_pkg.sv
// Shared constants, 16-bit word type and saturating arithmetic helpers
// for the LSP expand-2 block.
package lsp_expand_2_pkg;

    localparam logic [10:0] RELSPWED_BUF = 11'h100;
    localparam int          GAP1         = 10;
    localparam int          NC           = 5;
    localparam int          M            = 10;

    typedef logic signed [15:0] word_t;

    localparam word_t SAT_MAX = 16'sh7FFF;
    localparam word_t SAT_MIN = 16'sh8000;

    function automatic word_t sat_add(input word_t a, input word_t b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) return s[16] ? SAT_MIN : SAT_MAX;
        return s[15:0];
    endfunction

    function automatic word_t sat_sub(input word_t a, input word_t b);
        logic [16:0] s;
        s = {a[15], a} - {b[15], b};
        if (s[16] != s[15]) return s[16] ? SAT_MIN : SAT_MAX;
        return s[15:0];
    endfunction

    function automatic word_t shr1(input word_t a);
        return {a[15], a[15:1]};
    endfunction

endpackage

// File: rtl/lsp_expand_2_pipe_scratch.sv
// 4096x32 scratch memory with test-port / FSM ownership mux.
// Synchronous write, registered read (1-cycle latency); contents are never reset.
module scratch_memory_controller (
    input  logic        clk,
    input  logic        sel,
    input  logic [11:0] test_rd_addr,
    input  logic [11:0] test_wr_addr,
    input  logic [31:0] test_wr_data,
    input  logic        test_wr_en,
    input  logic [11:0] fsm_rd_addr,
    input  logic [11:0] fsm_wr_addr,
    input  logic [31:0] fsm_wr_data,
    input  logic        fsm_wr_en,
    output logic [31:0] rd_data
);

    logic [31:0] mem [4096];
    logic [31:0] rd_data_q;
    logic [11:0] rd_addr;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;

    always_comb begin
        rd_addr = fsm_rd_addr;
        wr_addr = fsm_wr_addr;
        wr_data = fsm_wr_data;
        wr_en   = fsm_wr_en;
        if (sel) begin
            rd_addr = test_rd_addr;
            wr_addr = test_wr_addr;
            wr_data = test_wr_data;
            wr_en   = test_wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lsp_expand_2_pipe.sv
// LSP expand-2 minimum-gap pass over buf[NC-1..M-1] held in scratch memory.
// Optional busy output is enabled by defining LSP_EXPAND_2_BUSY_EN.
module lsp_expand_2_pipe #(
    parameter logic [10:0] RELSPWED_BUF = lsp_expand_2_pkg::RELSPWED_BUF,
    parameter int          GAP          = lsp_expand_2_pkg::GAP1,
    parameter int          NC           = lsp_expand_2_pkg::NC,
    parameter int          M            = lsp_expand_2_pkg::M
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        expand2MuxSel,
    input  logic [11:0] testReadAddr,
    input  logic [11:0] testWriteAddr,
    input  logic [31:0] testMemOut,
    input  logic        testMemWriteEn,
    output logic [31:0] memIn,
    output logic        done
`ifdef LSP_EXPAND_2_BUSY_EN
    ,
    output logic        busy
`endif
);
    import lsp_expand_2_pkg::*;

    // state | meaning
    // IDLE  | waiting for start
    // RD_A  | issue read of buf[j-1]
    // RD_B  | issue read of buf[j], capture buf[j-1]
    // CALC  | compute tmp and the updated pair
    // WR_A  | write buf[j-1]
    // WR_B  | write buf[j]
    // NEXT  | advance j or finish
    // DONE  | result ready, done held high
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CALC, WR_A, WR_B, NEXT, DONE} state_t;

    localparam word_t GAP_W = word_t'(GAP);

    state_t      state_q, state_d;
    logic [3:0]  j_q, j_d;
    word_t       a_q, a_d, na_q, na_d, nb_q, nb_d;
    logic        done_q, done_d;
    logic        start_q, start_d;
    logic [3:0]  j_m1;
    word_t       b_word, diff, tmp;
    logic        tmp_pos;
    logic        fsm_we;
    logic [11:0] fsm_rd_addr, fsm_wr_addr;
    logic [31:0] fsm_wr_data;
    logic [31:0] mem_rd;

    function automatic logic [11:0] buf_addr(input logic [3:0] i);
        return {1'b0, RELSPWED_BUF[10:4], i};
    endfunction

    scratch_memory_controller u_mem (
        .clk         (clk),
        .sel         (expand2MuxSel),
        .test_rd_addr(testReadAddr),
        .test_wr_addr(testWriteAddr),
        .test_wr_data(testMemOut),
        .test_wr_en  (testMemWriteEn),
        .fsm_rd_addr (fsm_rd_addr),
        .fsm_wr_addr (fsm_wr_addr),
        .fsm_wr_data (fsm_wr_data),
        .fsm_wr_en   (fsm_we),
        .rd_data     (mem_rd)
    );

    assign j_m1    = j_q - 4'd1;
    assign b_word  = mem_rd[15:0];
    assign diff    = sat_sub(a_q, b_word);
    assign tmp     = shr1(sat_add(diff, GAP_W));
    assign tmp_pos = !tmp[15] && (tmp != 16'sd0);
    assign start_d = start;

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        a_d         = a_q;
        na_d        = na_q;
        nb_d        = nb_q;
        done_d      = done_q;
        fsm_we      = 1'b0;
        fsm_rd_addr = buf_addr(j_m1);
        fsm_wr_addr = buf_addr(j_m1);
        fsm_wr_data = {16'h0000, na_q};
        case (state_q)
            IDLE, DONE: begin
                // rising edge only, so a held start launches a single pass
                if (start && !start_q) begin
                    state_d = RD_A;
                    j_d     = 4'(NC);
                    done_d  = 1'b0;
                end
            end
            RD_A: state_d = RD_B;
            RD_B: begin
                fsm_rd_addr = buf_addr(j_q);
                a_d         = mem_rd[15:0];
                state_d     = CALC;
            end
            CALC: begin
                na_d    = sat_sub(a_q, tmp);
                nb_d    = sat_add(b_word, tmp);
                state_d = tmp_pos ? WR_A : NEXT;
            end
            WR_A: begin
                fsm_we  = 1'b1;
                state_d = WR_B;
            end
            WR_B: begin
                fsm_we      = 1'b1;
                fsm_wr_addr = buf_addr(j_q);
                fsm_wr_data = {16'h0000, nb_q};
                state_d     = NEXT;
            end
            NEXT: begin
                if (j_q == 4'(M - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    j_d     = j_q + 4'd1;
                    state_d = RD_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            j_q     <= '0;
            a_q     <= '0;
            na_q    <= '0;
            nb_q    <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            a_q     <= a_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

    assign memIn = mem_rd;
    assign done  = done_q;

`ifdef LSP_EXPAND_2_BUSY_EN
    assign busy = (state_q != IDLE) && (state_q != DONE);
`endif

endmodule

// File: tb/tb_lsp_expand_2_pipe.sv
// Scoreboard bench for lsp_expand_2_pipe: directed frames, reset abort, 120 random frames.
module tb_lsp_expand_2_pipe;
    import lsp_expand_2_pkg::*;

    localparam logic [11:0] BASE = {1'b0, RELSPWED_BUF[10:4], 4'h0};

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        expand2MuxSel;
    logic [11:0] testReadAddr;
    logic [11:0] testWriteAddr;
    logic [31:0] testMemOut;
    logic        testMemWriteEn;
    logic [31:0] memIn;
    logic        done;
`ifdef LSP_EXPAND_2_BUSY_EN
    logic        busy;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp32 [11];
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    lsp_expand_2_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .expand2MuxSel (expand2MuxSel),
        .testReadAddr  (testReadAddr),
        .testWriteAddr (testWriteAddr),
        .testMemOut    (testMemOut),
        .testMemWriteEn(testMemWriteEn),
        .memIn         (memIn),
        .done          (done)
`ifdef LSP_EXPAND_2_BUSY_EN
        ,
        .busy          (busy)
`endif
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic run_model();
        for (int j = NC; j < M; j++) begin
            int a, b, d, t;
            a = int'($signed(exp32[j-1][15:0]));
            b = int'($signed(exp32[j][15:0]));
            d = clamp16(a - b);
            t = clamp16(d + GAP1) >>> 1;
            if (t > 0) begin
                exp32[j-1] = {16'h0000, 16'(clamp16(a - t))};
                exp32[j]   = {16'h0000, 16'(clamp16(b + t))};
            end
        end
    endtask

    task automatic fill(input int v0, input int step);
        for (int i = 0; i < 10; i++) exp32[i] = {16'($urandom), 16'(v0 + step * i)};
        exp32[10] = $urandom;
    endtask

    task automatic set_lo(input int idx, input int v);
        exp32[idx][15:0] = 16'(v);
    endtask

    task automatic load_frame();
        expand2MuxSel = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            testWriteAddr  = BASE + 12'(i);
            testMemOut     = exp32[i];
            testMemWriteEn = 1'b1;
        end
        @(negedge clk);
        testMemWriteEn = 1'b0;
    endtask

    task automatic run_op(input int len);
        bit seen;
        int c;
        seen = 0;
        @(negedge clk);
        expand2MuxSel = 1'b0;
        start = 1'b1;
        for (c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (c == 0) chk("done_clr", {31'd0, done}, 32'd0);
            if (c == len - 1) start = 1'b0;
            if (done && !seen) begin
                seen = 1;
                n_cmp++;
                assert (c <= 40) else begin
                    n_mis++;
                    $error("FAIL latency observed=%0d expected<=40", c);
                end
            end
            if (seen && c >= len - 1) break;
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_mis++;
            $error("FAIL done_timeout observed=0 expected=1");
        end
        repeat (3) @(posedge clk);
        #1 chk("done_hold", {31'd0, done}, 32'd1);
    endtask

    task automatic readback(input string tag);
        logic [31:0] e;
        @(negedge clk);
        expand2MuxSel  = 1'b1;
        testMemWriteEn = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            testReadAddr = BASE + 12'(i);
            sb_q.push_back(exp32[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            chk($sformatf("%s[%0d]", tag, i), memIn, e);
        end
    endtask

    task automatic frame(input string tag, input int len);
        load_frame();
        run_model();
        run_op(len);
        readback(tag);
    endtask

    task automatic set_tail();
        set_lo(6, 9000); set_lo(7, 10000); set_lo(8, 11000); set_lo(9, 12000);
    endtask

    task automatic set_chain();
        fill(1000, 1000);
        for (int i = 4; i < 10; i++) set_lo(i, 5000);
    endtask

    initial begin
        int hi_cnt;
        reset = 1'b1; start = 1'b0; expand2MuxSel = 1'b1;
        testReadAddr = '0; testWriteAddr = '0; testMemOut = '0; testMemWriteEn = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1 chk("post_rst_done", {31'd0, done}, 32'd0);

        fill(1000, 1000);
        frame("lin", 3);

        fill(1000, 1000); set_lo(4, 8000); set_lo(5, 8000); set_tail();
        frame("eq", 3);

        fill(1000, 1000); set_lo(4, 8000); set_lo(5, 8010); set_tail();
        frame("b10", 3);
        fill(1000, 1000); set_lo(4, 8000); set_lo(5, 8009); set_tail();
        frame("b9", 3);
        fill(1000, 1000); set_lo(4, 8000); set_lo(5, 8008); set_tail();
        frame("b8", 3);

        fill(1000, 1000); set_lo(8, 32767); set_lo(9, -32768);
        frame("sat", 3);

        set_chain();
        frame("chain", 3);

        set_chain();
        frame("hold", 50);

        // reset while the FSM sits in CALC for j=NC, then rerun from memory
        set_chain();
        load_frame();
        @(negedge clk);
        expand2MuxSel = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        reset = 1'b1;
        #1 chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (done) hi_cnt++;
        end
        chk("abort_idle", 32'(hi_cnt), 32'd0);
        run_model();
        run_op(3);
        readback("abort");

        for (int f = 0; f < 120; f++) begin
            if (f % 4 == 0) begin
                for (int i = 0; i < 11; i++) exp32[i] = $urandom;
            end else begin
                int v0;
                v0 = int'($urandom_range(0, 20000)) - 10000;
                for (int i = 0; i < 10; i++)
                    exp32[i] = {16'($urandom), 16'(v0 + int'($urandom_range(0, 60)) - 30)};
                exp32[10] = $urandom;
            end
            frame($sformatf("rnd%0d", f), 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lsp_expand_2_pipe.md
LSP_EXPAND_2_PIPE -- requirements
Module: lsp_expand_2_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter RELSPWED_BUF, default from the shared package, SHALL give the 11-bit buffer base; element i is at address {1'b0, RELSPWED_BUF[10:4], i[3:0]}.
REQ-003 Parameter GAP, default 10 (GAP1, Q13), SHALL give the minimum-gap constant.
REQ-004 Parameter NC, default 5, and parameter M, default 10, SHALL give the first pair index and the buffer length.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  async active-high.
- start  in  1  begin operation; level-tolerant, sampled in IDLE only.
- expand2MuxSel  in  1  1 = test port owns scratch memory; 0 = FSM owns it.
- testReadAddr  in  12  test read address.
- testWriteAddr  in  12  test write address.
- testMemOut  in  32  test write data.
- testMemWriteEn  in  1  test write enable.
- memIn  out  32  scratch memory read data, for the muxed read address.
- done  out  1  operation complete.

Function
REQ-006 The block SHALL contain a 4096x32 synchronous scratch memory: write on posedge when enabled, registered read with 1-cycle latency.
REQ-007 When expand2MuxSel=1, read/write address, data and enable SHALL come from the test ports; when 0, they SHALL come from the FSM.
REQ-008 Operation SHALL be, for j = NC..M-1 in ascending order, each step using values updated by earlier steps, on 16-bit words in the low halves:
- diff = sub(buf[j-1], buf[j]), saturating.
- tmp = shr(add(diff, GAP), 1), saturating add, arithmetic shift.
- If tmp > 0 (signed): buf[j-1] = sub(buf[j-1], tmp) and buf[j] = add(buf[j], tmp).
REQ-009 All add and sub operations SHALL saturate to the range -32768..32767.
REQ-010 Written words SHALL be {16'h0000, result}; the upper 16 bits of read data SHALL be ignored.
REQ-011 FSM states SHALL be IDLE -> RD_A -> RD_B -> CALC -> WR_A -> WR_B -> NEXT, looping per j, then DONE. CALC goes directly to NEXT when tmp <= 0.
REQ-012 When tmp <= 0, no memory write SHALL occur for that j.
REQ-013 done SHALL rise no later than 40 cycles after start is sampled, and SHALL stay high until the next start is accepted in IDLE/DONE or until reset.
REQ-014 start asserted while busy SHALL be ignored; start held high over several cycles SHALL launch exactly one operation.
REQ-015 Addresses 0..NC-2 of the buffer, and all other memory, SHALL never be written by the FSM.

Reset
REQ-016 Reset SHALL force the FSM to IDLE and clear done, the j counter and the datapath registers.
REQ-017 Reset mid-operation SHALL abort the operation; memory SHALL keep its contents, and partial results are acceptable.
REQ-018 Memory contents SHALL NOT be reset.

Configuration
REQ-019 With macro LSP_EXPAND_2_BUSY_EN defined, an extra output busy (1 bit) SHALL be present, high in every non-IDLE/non-DONE state. Without the macro, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-020 A shared package SHALL hold RELSPWED_BUF, GAP1=10, NC=5, M=10, the 16-bit word type and the saturation limits; the FSM state enum SHALL be local.
REQ-021 The scratch memory SHALL be one sub-module, scratch_memory_controller; the saturating add/sub/shr SHALL be functions in the package.

Verification
REQ-022 Buffer 1000,2000,...,10000 -> output unchanged; done rises; no FSM writes.
REQ-023 buf[4]=buf[5]=8000, buf[6..9]=9000,10000,11000,12000 -> buf[4]=7995, buf[5]=8005, rest unchanged.
REQ-024 Boundary for buf[4],buf[5]:
- 8000,8010 (diff -10, tmp 0) -> unchanged.
- 8000,8009 (tmp 0) -> unchanged.
- 8000,8008 (tmp 1) -> 7999,8009.
REQ-025 Saturation: buf[8]=0x7FFF, buf[9]=0x8000 -> tmp=16383; buf[8]=0x4000, buf[9]=0xBFFF, stored as 0x0000BFFF.
REQ-026 Chain: buf[4..9] all 5000 -> j=5 gives 4995,5005; j=6 (tmp 7) gives buf[5]=4998, buf[6]=5007; steps continue sequentially.
REQ-027 Reset pulsed in CALC -> done=0, FSM in IDLE; a new start then completes correctly from the current memory contents.
REQ-028 The bench SHALL run 120 back-to-back frames with a 3-cycle start pulse each, readback via the test port.
